gcd_lcm_engine: RTL and testbench



---
 rtl/gcd_lcm_pkg.sv | 44 ++++
 rtl/seq_divider.sv | 68 ++++++
 rtl/gcd_lcm_engine.sv | 202 ++++++++++++++++++++
 tb/tb_gcd_lcm_engine.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM engine.
// Holds the FSM state encoding, the REDUCE and latency bounds checked by
// assertions, and a Euclidean reference GCD meant for testbench use only.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STRIP  = 3'd1,
    S_REDUCE = 3'd2,
    S_DIV    = 3'd3,
    S_MUL    = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  // REDUCE never takes more than REDUCE_FACTOR*DATA_W cycles.
  localparam int unsigned REDUCE_FACTOR  = 4;
  // Acceptance-to-result latency never exceeds LATENCY_FACTOR*DATA_W+LATENCY_SLACK.
  localparam int unsigned LATENCY_FACTOR = 6;
  localparam int unsigned LATENCY_SLACK  = 4;

  function automatic int unsigned reduce_bound(input int unsigned w);
    return REDUCE_FACTOR * w;
  endfunction

  function automatic int unsigned latency_bound(input int unsigned w);
    return LATENCY_FACTOR * w + LATENCY_SLACK;
  endfunction

  // Euclidean GCD; gcd(x,0)=x and gcd(0,0)=0.
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x;
    int unsigned y;
    int unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, DATA_W cycles.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       load dividend/divisor and begin (ignored semantics while busy
//               are not needed: the caller only starts when idle)
//   dividend    numerator, divisor  denominator (must be non-zero)
//   busy        high for exactly DATA_W cycles after start
//   done        high during the final iteration cycle; quotient is complete
//               on the edge that ends that cycle
//   quotient    result register (holds dividend during the iterations)
module seq_divider #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int unsigned ITER_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [ITER_W-1:0] iter_q;
  logic [DATA_W:0]   rem_sh_c;
  logic [DATA_W+1:0] diff_c;
  logic              fits_c;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh_c = {rem_q, quotient[DATA_W-1]};
    diff_c   = {1'b0, rem_sh_c} - {2'b00, dvs_q};
    fits_c   = ~diff_c[DATA_W+1];
  end

  // Iteration registers; quotient bits shift in from the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      iter_q   <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      dvs_q    <= divisor;
      quotient <= dividend;
      iter_q   <= ITER_W'(DATA_W);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      quotient <= {quotient[DATA_W-2:0], fits_c};
      rem_q    <= fits_c ? diff_c[DATA_W-1:0] : rem_sh_c[DATA_W-1:0];
      iter_q   <= iter_q - ITER_W'(1);
      // Flag the last iteration one cycle ahead so the caller can leave on it.
      done     <= (iter_q == ITER_W'(2));
      if (iter_q == ITER_W'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_engine.sv
// Handshaked GCD/LCM engine: binary (Stein) GCD, sequential restoring divide
// of A by the GCD, then one registered multiply for the LCM.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   a_in, b_in        operands, taken when in_vld && in_rdy
//   in_vld / in_rdy   input handshake; in_rdy is registered from state only
//   gcd_out, lcm_out  results, registered, change only on entry to OUT
//   zero_out          at least one operand was zero (gcd=A|B, lcm=0)
//   out_vld / out_rdy output handshake; result held until accepted
module gcd_lcm_engine
  import gcd_lcm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   b_in,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [DATA_W-1:0]   gcd_out,
  output logic [2*DATA_W-1:0] lcm_out,
  output logic                zero_out,
  output logic                out_vld,
  input  logic                out_rdy
);

  localparam int unsigned LCM_W        = 2 * DATA_W;
  localparam int unsigned REDUCE_BOUND = REDUCE_FACTOR * DATA_W;
  localparam int unsigned RED_W        = $clog2(REDUCE_BOUND + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d;
  logic [DATA_W-1:0] b_hold_q, b_hold_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] gcd_d;
  logic [LCM_W-1:0]  lcm_d;
  logic              zero_d;
  logic              out_vld_d;
  logic              in_rdy_d;
  logic [RED_W-1:0]  red_cnt_q;

  logic [DATA_W-1:0] g_shift_c;
  logic              div_start_c;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;

  // Quotient A0/g; exact because g divides A0.
  seq_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (a_hold_q),
    .divisor  (g_shift_c),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_hold_d    = a_hold_q;
    b_hold_d    = b_hold_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    g_d         = g_q;
    gcd_d       = gcd_out;
    lcm_d       = lcm_out;
    zero_d      = zero_out;
    out_vld_d   = out_vld;
    div_start_c = 1'b0;
    // Restores the common power of two removed during STRIP.
    g_shift_c   = a_q << k_q;

    case (state_q)
      S_IDLE: begin
        if (in_vld && in_rdy) begin
          a_hold_d = a_in;
          b_hold_d = b_in;
          a_d      = a_in;
          b_d      = b_in;
          k_d      = '0;
          if ((a_in == '0) || (b_in == '0)) begin
            gcd_d     = a_in | b_in;
            lcm_d     = '0;
            zero_d    = 1'b1;
            out_vld_d = 1'b1;
            state_d   = S_OUT;
          end else begin
            state_d = S_STRIP;
          end
        end
      end
      S_STRIP: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + CNT_W'(1);
        end else begin
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q == b_q) begin
          g_d         = g_shift_c;
          div_start_c = 1'b1;
          state_d     = S_DIV;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // lcm <= A0*B0, so the 2*DATA_W product cannot overflow.
        gcd_d     = g_q;
        lcm_d     = LCM_W'(div_quo) * LCM_W'(b_hold_q);
        zero_d    = 1'b0;
        out_vld_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_rdy_d = (state_d == S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_hold_q <= '0;
      b_hold_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      g_q      <= '0;
      gcd_out  <= '0;
      lcm_out  <= '0;
      zero_out <= 1'b0;
      out_vld  <= 1'b0;
      in_rdy   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      g_q      <= g_d;
      gcd_out  <= gcd_d;
      lcm_out  <= lcm_d;
      zero_out <= zero_d;
      out_vld  <= out_vld_d;
      in_rdy   <= in_rdy_d;
    end
  end

  // Cycles spent so far in the current REDUCE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_cnt_q <= '0;
    end else if (state_q == S_REDUCE) begin
      red_cnt_q <= red_cnt_q + RED_W'(1);
    end else begin
      red_cnt_q <= '0;
    end
  end

  a_reduce_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_REDUCE) |-> (red_cnt_q < RED_W'(REDUCE_BOUND)));

  a_div_running: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_DIV) |-> div_busy);

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Scoreboard bench: one DATA_W=8 instance for directed scenarios and three
// instances (DATA_W 4, 8, 12) under random operands and random back-pressure.
module tb_gcd_lcm_engine;
  import gcd_lcm_pkg::*;

  localparam int unsigned N_RND      = 600;
  localparam int unsigned RDY_TMO    = 400;
  localparam int unsigned GLOBAL_TMO = 90000;

  typedef struct {
    int unsigned     gcd;
    longint unsigned lcm;
    bit              zero;
    int unsigned     acc;
    int unsigned     bound;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          rnd_done [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_le(input string name, input int unsigned act, input int unsigned lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s actual=%0d required<=%0d", name, act, lim);
    end
  endtask

  // Reference: gcd from the package, lcm = (a/gcd)*b, zero operands give lcm 0.
  function automatic exp_t mk_exp(input int unsigned a, input int unsigned b,
                                  input int unsigned acc, input int unsigned w);
    exp_t e;
    e.gcd   = ref_gcd(a, b);
    e.zero  = (a == 0) || (b == 0);
    e.lcm   = e.zero ? 64'd0 : longint'(a / e.gcd) * longint'(b);
    e.acc   = acc;
    e.bound = 6 * w + 4;
    return e;
  endfunction

  // ---------------- directed instance ----------------
  logic        d_rst_n;
  logic [7:0]  d_a, d_b, d_gcd;
  logic [15:0] d_lcm;
  logic        d_in_vld, d_in_rdy, d_zero, d_out_vld, d_out_rdy;
  exp_t        d_q[$];
  logic        r_rst_n;

  gcd_lcm_engine #(.DATA_W(8)) u_dir (
    .clk      (clk),
    .rst_n    (d_rst_n),
    .a_in     (d_a),
    .b_in     (d_b),
    .in_vld   (d_in_vld),
    .in_rdy   (d_in_rdy),
    .gcd_out  (d_gcd),
    .lcm_out  (d_lcm),
    .zero_out (d_zero),
    .out_vld  (d_out_vld),
    .out_rdy  (d_out_rdy)
  );

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic d_send(input int unsigned a, input int unsigned b);
    int unsigned n;
    int unsigned acc;
    bit x;
    d_a = 8'(a);
    d_b = 8'(b);
    d_in_vld = 1'b1;
    n = 0;
    x = 1'b0;
    acc = 0;
    while (!x && n < RDY_TMO) begin
      @(negedge clk);
      x = d_in_rdy;
      acc = cyc;
      @(posedge clk);
      n++;
    end
    if (x) d_q.push_back(mk_exp(a, b, acc, 8));
    else check("dir_accept_timeout", 64'(x), 64'd1);
    #1 d_in_vld = 1'b0;
  endtask

  task automatic d_drain();
    int unsigned n;
    n = 0;
    while ((d_q.size() != 0 || d_out_vld) && n < RDY_TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dir_drain", 64'(d_q.size()), 64'd0);
  endtask

  // Directed-instance monitor: latency at result rise, data at transfer.
  initial begin : d_mon
    bit prev;
    int unsigned lat;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!d_rst_n) begin
        prev = 1'b0;
      end else begin
        if (d_out_vld && !prev) begin
          if (d_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dir_unexpected_out gcd=%0d lcm=%0d required=none", d_gcd, d_lcm);
          end else begin
            lat = cyc - d_q[0].acc;
            if (d_q[0].zero) check("dir_lat_zero", 64'(lat), 64'd1);
            else check_le("dir_lat", lat, d_q[0].bound);
          end
        end
        if (d_out_vld && d_out_rdy && d_q.size() != 0) begin
          e = d_q.pop_front();
          check("dir_gcd", 64'(d_gcd), 64'(e.gcd));
          check("dir_lcm", 64'(d_lcm), 64'(e.lcm));
          check("dir_zero", 64'(d_zero), 64'(e.zero));
        end
        prev = d_out_vld;
      end
    end
  end

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned W = 4 + 4 * g;
    logic [W-1:0]   a, b, gcd;
    logic [2*W-1:0] lcm;
    logic           in_vld, in_rdy, zero, out_vld, out_rdy;
    exp_t           q[$];

    gcd_lcm_engine #(.DATA_W(W)) u_dut (
      .clk      (clk),
      .rst_n    (r_rst_n),
      .a_in     (a),
      .b_in     (b),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .gcd_out  (gcd),
      .lcm_out  (lcm),
      .zero_out (zero),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy)
    );

    initial begin : drv
      int unsigned av, bv, n, acc;
      bit x;
      in_vld = 1'b0;
      a = '0;
      b = '0;
      wait (r_rst_n);
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N_RND); i++) begin
        av = $urandom_range(0, (1 << W) - 1);
        bv = $urandom_range(0, (1 << W) - 1);
        if ($urandom_range(0, 15) == 0) av = 0;
        if ($urandom_range(0, 15) == 0) bv = 0;
        a = W'(av);
        b = W'(bv);
        in_vld = 1'b1;
        n = 0;
        x = 1'b0;
        acc = 0;
        while (!x && n < RDY_TMO) begin
          @(negedge clk);
          x = in_rdy;
          acc = cyc;
          @(posedge clk);
          n++;
        end
        if (x) q.push_back(mk_exp(av, bv, acc, W));
        else check($sformatf("w%0d_accept_timeout", W), 64'(x), 64'd1);
        #1 in_vld = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    initial begin : bp
      out_rdy = 1'b1;
      forever begin
        @(posedge clk);
        #1 out_rdy = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin : mon
      bit prev;
      int unsigned got, lat;
      exp_t e;
      prev = 1'b0;
      got = 0;
      wait (r_rst_n);
      while (got < N_RND) begin
        @(negedge clk);
        if (out_vld && !prev) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w%0d_unexpected_out gcd=%0d required=none", W, gcd);
          end else begin
            lat = cyc - q[0].acc;
            if (q[0].zero) check($sformatf("w%0d_lat_zero", W), 64'(lat), 64'd1);
            else check_le($sformatf("w%0d_lat", W), lat, q[0].bound);
          end
        end
        if (out_vld && out_rdy && q.size() != 0) begin
          e = q.pop_front();
          check($sformatf("w%0d_gcd", W), 64'(gcd), 64'(e.gcd));
          check($sformatf("w%0d_lcm", W), 64'(lcm), 64'(e.lcm));
          check($sformatf("w%0d_zero", W), 64'(zero), 64'(e.zero));
          got++;
        end
        prev = out_vld;
      end
      rnd_done[g] = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int unsigned n;
    d_rst_n   = 1'b0;
    r_rst_n   = 1'b0;
    d_a       = '0;
    d_b       = '0;
    d_in_vld  = 1'b0;
    d_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", 64'(d_in_rdy), 64'd1);
    check("rst_out_vld", 64'(d_out_vld), 64'd0);
    check("rst_gcd", 64'(d_gcd), 64'd0);
    check("rst_lcm", 64'(d_lcm), 64'd0);
    check("rst_zero", 64'(d_zero), 64'd0);
    d_rst_n = 1'b1;
    r_rst_n = 1'b1;
    @(posedge clk);
    #1;

    d_send(12, 18);
    d_send(0, 9);
    d_send(0, 0);
    d_send(255, 254);
    d_send(128, 64);
    d_drain();

    // Back-pressure: result held, busy engine ignores in_vld.
    d_out_rdy = 1'b0;
    d_send(20, 8);
    n = 0;
    while (!d_out_vld && n < RDY_TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_out_vld_rise", 64'(d_out_vld), 64'd1);
    for (int i = 0; i < 5; i++) begin
      d_a = 8'd3;
      d_b = 8'd5;
      d_in_vld = 1'b1;
      @(negedge clk);
      check("bp_in_rdy", 64'(d_in_rdy), 64'd0);
      check("bp_out_vld", 64'(d_out_vld), 64'd1);
      check("bp_gcd", 64'(d_gcd), 64'd4);
      check("bp_lcm", 64'(d_lcm), 64'd40);
      @(posedge clk);
      #1 d_in_vld = 1'b0;
      @(posedge clk);
      #1;
    end
    d_out_rdy = 1'b1;
    d_drain();

    // Reset while the divider is running.
    d_send(100, 75);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_out_vld", 64'(d_out_vld), 64'd0);
    d_rst_n = 1'b0;
    #1;
    check("arst_in_rdy", 64'(d_in_rdy), 64'd1);
    check("arst_out_vld", 64'(d_out_vld), 64'd0);
    check("arst_gcd", 64'(d_gcd), 64'd0);
    check("arst_lcm", 64'(d_lcm), 64'd0);
    check("arst_zero", 64'(d_zero), 64'd0);
    d_q.delete();
    @(posedge clk);
    #1;
    check("arst_hold_out_vld", 64'(d_out_vld), 64'd0);
    d_rst_n = 1'b1;
    @(posedge clk);
    #1;
    d_send(7, 21);
    d_drain();

    n = 0;
    while (!(rnd_done[0] && rnd_done[1] && rnd_done[2]) && n < GLOBAL_TMO) begin
      @(posedge clk);
      n++;
    end
    check("rnd_complete", 64'(rnd_done[0] && rnd_done[1] && rnd_done[2]), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
